// File: rtl/store_buffer_pkg.sv
// Shared types and default sizing for the MEM-stage posted store buffer.
// The store beat bus and the buffered entry are defined here so both sides agree on widths.
package store_buffer_pkg;

   localparam int SB_ADDR_W = 32;
   localparam int SB_DATA_W = 32;
   localparam int SB_DEPTH  = 4;

   typedef struct packed {
      logic [SB_ADDR_W-1:0]   addr;
      logic [SB_DATA_W-1:0]   w_data;
      logic [SB_DATA_W/8-1:0] write_en;
   } mem_cntrl_bus_t;

   typedef struct packed {
      logic [SB_ADDR_W-3:0]   word_addr;
      logic [SB_DATA_W-1:0]   data;
      logic [SB_DATA_W/8-1:0] be;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Data-memory write port used by the store buffer to drain entries (req/gnt handshake).
interface store_buffer_if
   import store_buffer_pkg::*;
#(
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
);
   logic                  req;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   be;
   logic                  gnt;

   modport master (output req, addr, wdata, be, input gnt);
   modport slave  (input req, addr, wdata, be, output gnt);
endinterface

// File: rtl/store_buffer_cmp.sv
// Per-entry load overlap compare: same word and at least one shared byte lane.
module store_buffer_cmp #(
   parameter int WA_W = 30,
   parameter int BE_W = 4
) (
   input  logic            vld,
   input  logic [WA_W-1:0] ent_word,
   input  logic [BE_W-1:0] ent_be,
   input  logic [WA_W-1:0] ld_word,
   input  logic [BE_W-1:0] ld_be,
   output logic            hit
);
   assign hit = vld && (ent_word == ld_word) && (|(ent_be & ld_be));
endmodule

// File: rtl/store_buffer.sv
// In-order posted store buffer: queues byte-enabled store beats, drains them over req/gnt,
// and raises a load hazard while a pending store covers any byte the load wants.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      st_valid_i,
   input  mem_cntrl_bus_t            st_i,
   output logic                      st_ready_o,
   input  logic                      ld_valid_i,
   input  logic [ADDR_W-1:0]         ld_addr_i,
   input  logic [DATA_W/8-1:0]       ld_be_i,
   output logic                      ld_hazard_o,
   store_buffer_if.master            mem,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BE_W  = DATA_W / 8;

   sb_entry_t              ent_q [DEPTH];
   logic [DEPTH-1:0]       vld_q;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q;
   logic                   full, empty, push, pop;
   logic [DEPTH-1:0]       hit;
   logic                   unused_bits;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // Ready depends only on occupancy so the store path never waits on the memory grant.
   assign st_ready_o = rst_ni && !full;
   assign push       = st_valid_i && st_ready_o && (|st_i.write_en);
   assign pop        = mem.req && mem.gnt;

   assign mem.req   = !empty;
   assign mem.addr  = {ent_q[rd_ptr_q].word_addr, 2'b00};
   assign mem.wdata = ent_q[rd_ptr_q].data;
   assign mem.be    = ent_q[rd_ptr_q].be;

   assign empty_o = empty;
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Payload storage carries no reset; validity is tracked by vld_q and count_q.
   always_ff @(posedge clk_i) begin
      if (push) begin
         ent_q[wr_ptr_q].word_addr <= st_i.addr[ADDR_W-1:2];
         ent_q[wr_ptr_q].data      <= st_i.w_data;
         ent_q[wr_ptr_q].be        <= st_i.write_en;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      store_buffer_cmp #(.WA_W(ADDR_W-2), .BE_W(BE_W)) u_cmp (
         .vld      (vld_q[g]),
         .ent_word (ent_q[g].word_addr),
         .ent_be   (ent_q[g].be),
         .ld_word  (ld_addr_i[ADDR_W-1:2]),
         .ld_be    (ld_be_i),
         .hit      (hit[g])
      );
   end

   // The entry popping this cycle still raises the hazard; the load simply retries.
   assign ld_hazard_o = ld_valid_i && (|hit);

   assign unused_bits = ^{st_i.addr[1:0], ld_addr_i[1:0]};

   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !full);
   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> !empty);
   a_count_range:  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CNT_W'(DEPTH));
   a_ld_st_excl:   assert property (@(posedge clk_i) disable iff (!rst_ni) !(ld_valid_i && st_valid_i));
   a_req_stable:   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (mem.req && !mem.gnt) |=> (mem.req && $stable(mem.addr) && $stable(mem.wdata) && $stable(mem.be)));

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain order, full back-pressure, load hazard, reset flush.
module tb_store_buffer;
   import store_buffer_pkg::*;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   logic           st_valid_i;
   mem_cntrl_bus_t st_i;
   logic           st_ready_o;
   logic           ld_valid_i;
   logic [31:0]    ld_addr_i;
   logic [3:0]     ld_be_i;
   logic           ld_hazard_o;
   logic           empty_o;
   logic [2:0]     count_o;

   int n_cmp = 0;
   int n_bad = 0;

   store_buffer_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

   store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .st_valid_i  (st_valid_i),
      .st_i        (st_i),
      .st_ready_o  (st_ready_o),
      .ld_valid_i  (ld_valid_i),
      .ld_addr_i   (ld_addr_i),
      .ld_be_i     (ld_be_i),
      .ld_hazard_o (ld_hazard_o),
      .mem         (mem_if.master),
      .empty_o     (empty_o),
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      st_valid_i     = v;
      st_i.addr      = a;
      st_i.w_data    = d;
      st_i.write_en  = be;
   endtask

   logic [31:0] exp_addr [5] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};

   initial begin
      rst_ni     = 1'b0;
      set_st(1'b0, '0, '0, '0);
      ld_valid_i = 1'b0;
      ld_addr_i  = '0;
      ld_be_i    = '0;
      mem_if.gnt = 1'b0;
      #1;
      chk("ready_in_reset", st_ready_o, 1'b0);
      tick();
      tick();
      rst_ni = 1'b1;
      #1;
      chk("rst_count", count_o, 3'd0);
      chk("rst_empty", empty_o, 1'b1);
      chk("rst_req", mem_if.req, 1'b0);
      chk("rst_hazard", ld_hazard_o, 1'b0);
      chk("rst_ready", st_ready_o, 1'b1);

      // Byte store to 0x103, grant always on
      mem_if.gnt = 1'b1;
      set_st(1'b1, 32'h103, 32'hAB00_0000, 4'b1000);
      tick();
      set_st(1'b0, '0, '0, '0);
      chk("sb_req", mem_if.req, 1'b1);
      chk("sb_addr", mem_if.addr, 32'h100);
      chk("sb_be", mem_if.be, 4'b1000);
      chk("sb_byte", mem_if.wdata[31:24], 8'hAB);
      tick();
      chk("sb_empty_after", empty_o, 1'b1);
      chk("sb_req_after", mem_if.req, 1'b0);

      // Fill with grant held off
      mem_if.gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_st(1'b1, exp_addr[i], 32'h1000 + i, 4'hF);
         tick();
      end
      chk("full_count", count_o, 3'd4);
      chk("full_ready", st_ready_o, 1'b0);
      set_st(1'b1, exp_addr[4], 32'h1004, 4'hF);
      tick();
      chk("held_count", count_o, 3'd4);
      chk("held_ready", st_ready_o, 1'b0);

      // Release grant: pop while full refuses the waiting push
      mem_if.gnt = 1'b1;
      #1;
      chk("drain0_addr", mem_if.addr, exp_addr[0]);
      chk("drain0_data", mem_if.wdata, 32'h1000);
      tick();
      chk("popfull_count", count_o, 3'd3);
      chk("popfull_ready", st_ready_o, 1'b1);
      chk("drain1_addr", mem_if.addr, exp_addr[1]);
      tick();
      set_st(1'b0, '0, '0, '0);
      chk("pushpop_count", count_o, 3'd3);
      for (int i = 2; i < 5; i++) begin
         chk("drain_addr", mem_if.addr, exp_addr[i]);
         chk("drain_data", mem_if.wdata, 32'h1000 + i);
         tick();
      end
      chk("drained_empty", empty_o, 1'b1);
      chk("drained_count", count_o, 3'd0);

      // Load hazard against a pending halfword store
      mem_if.gnt = 1'b0;
      set_st(1'b1, 32'h42, 32'h1234_0000, 4'b1100);
      tick();
      set_st(1'b0, '0, '0, '0);
      ld_addr_i = 32'h43; ld_be_i = 4'b1000;
      #1;
      chk("hz_novalid", ld_hazard_o, 1'b0);
      ld_valid_i = 1'b1;
      #1;
      chk("hz_overlap", ld_hazard_o, 1'b1);
      ld_addr_i = 32'h41; ld_be_i = 4'b0010;
      #1;
      chk("hz_other_byte", ld_hazard_o, 1'b0);
      ld_addr_i = 32'h47; ld_be_i = 4'b1000;
      #1;
      chk("hz_other_word", ld_hazard_o, 1'b0);
      ld_valid_i = 1'b0;
      mem_if.gnt = 1'b1;
      tick();
      mem_if.gnt = 1'b0;
      ld_valid_i = 1'b1; ld_addr_i = 32'h43; ld_be_i = 4'b1000;
      #1;
      chk("hz_after_grant", ld_hazard_o, 1'b0);
      ld_valid_i = 1'b0;

      // Reset with entries pending and no grant
      for (int i = 0; i < 3; i++) begin
         set_st(1'b1, 32'h80 + 4 * i, 32'hC0 + i, 4'hF);
         tick();
      end
      set_st(1'b0, '0, '0, '0);
      chk("prerst_count", count_o, 3'd3);
      rst_ni = 1'b0;
      #1;
      chk("midrst_ready", st_ready_o, 1'b0);
      tick();
      rst_ni = 1'b1;
      #1;
      chk("postrst_count", count_o, 3'd0);
      chk("postrst_req", mem_if.req, 1'b0);
      chk("postrst_empty", empty_o, 1'b1);
      mem_if.gnt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("no_stale_req", mem_if.req, 1'b0);
      end
      mem_if.gnt = 1'b0;

      // Zero byte-enable beat is swallowed
      set_st(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0000);
      #1;
      chk("zbe_ready", st_ready_o, 1'b1);
      tick();
      set_st(1'b0, '0, '0, '0);
      chk("zbe_count", count_o, 3'd0);
      chk("zbe_req", mem_if.req, 1'b0);
      tick();
      chk("zbe_req_later", mem_if.req, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted write buffer that sits directly downstream of the store byte-lane controller in the MEM stage.
- Accepts byte-aligned store beats (word address, lane-placed data, 4-bit byte enable) and holds them in an in-order FIFO.
- Drains entries to the data-memory write port over a req/gnt handshake.
- Flags a load hazard to the pipeline when an in-flight load overlaps bytes still pending in the buffer.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
ADDR_W, 32, byte address width
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
clk_i  in  1  core clock
rst_ni  in  1  synchronous active-low reset
st_valid_i  in  1  store beat valid from store controller
st_i  in  core::mem_cntrl_bus_t  store beat; uses .addr, .w_data, .write_en
st_ready_o  out  1  buffer can accept a beat this cycle
ld_valid_i  in  1  load in MEM stage this cycle
ld_addr_i  in  ADDR_W  load byte address
ld_be_i  in  DATA_W/8  load byte lanes
ld_hazard_o  out  1  load overlaps a pending store; pipeline must stall
mem_req_o  out  1  write request to data memory
mem_addr_o  out  ADDR_W  word-aligned write address, [1:0]=0
mem_wdata_o  out  DATA_W  write data
mem_be_o  out  DATA_W/8  byte enables
mem_gnt_i  in  1  memory accepted the write this cycle
empty_o  out  1  no pending entries
count_o  out  $clog2(DEPTH)+1  number of pending entries

Behaviour:
- Single clock domain clk_i. rst_ni is synchronous, active-low, sampled on rising edge.
- Reset values: count=0, wr_ptr=0, rd_ptr=0, all entry valid bits 0. Entry data/addr/be are not reset.
- Outputs after reset: mem_req_o=0, empty_o=1, count_o=0, ld_hazard_o=0, st_ready_o=1. While rst_ni=0, st_ready_o is forced to 0.
- Entry contents: word_addr = st_i.addr[ADDR_W-1:2], data = st_i.w_data, be = st_i.write_en.
- Enqueue fires when st_valid_i && st_ready_o && st_i.write_en != 0.
  - Beats with write_en == 0 are accepted and dropped (no entry, no count change).
- st_ready_o = (count != DEPTH). It has no combinational dependence on mem_gnt_i. When full, the upstream stalls even if a pop occurs the same cycle.
- Drain is strictly FIFO.
  - mem_req_o = !empty.
  - mem_addr_o = {head.word_addr, 2'b00}, mem_wdata_o = head.data, mem_be_o = head.be.
  - Pop fires when mem_req_o && mem_gnt_i.
- Drain handshake rules:
  - Once mem_req_o is asserted, the request and its payload stay stable until granted.
  - mem_gnt_i while mem_req_o=0 is ignored.
  - Best-case latency: a beat enqueued at edge N requests from cycle N+1 and can pop at edge N+1 if granted.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When empty, a push is never bypassed to memory the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- Hazard detection is combinational:
  - ld_hazard_o = ld_valid_i && OR over valid entries of (entry.word_addr == ld_addr_i[ADDR_W-1:2] && (entry.be & ld_be_i) != 0).
  - The entry being popped this cycle still counts, which is conservative.
  - A store beat enqueuing this cycle is not compared. Load and store are mutually exclusive per cycle; an assertion checks !(ld_valid_i && st_valid_i).
- Partial overlap with different bytes of the same word is not a hazard.
- No forwarding: the pipeline holds the load until ld_hazard_o clears.
- Reset mid-operation discards all pending stores. mem_req_o falls in the cycle after the reset edge, including when a grant was outstanding. The memory side must tolerate this.
- Assertions:
  - No push when full.
  - No pop when empty.
  - count_o <= DEPTH.
  - Payload stable while mem_req_o && !mem_gnt_i.

Decomposition:
- core package gains:
  - sb_entry_t {logic [ADDR_W-3:0] word_addr; logic [DATA_W-1:0] data; logic [DATA_W/8-1:0] be;}
  - SB_DEPTH constant (default 4), used by the top level.
- A single file with no sub-module is sufficient. The overlap compare may be a generate loop inside store_buffer.

Test Plan:
- Reset, then SB to 0x103 data 0xAB, with gnt tied 1 -> one cycle later mem_req_o=1, mem_addr_o=0x100, mem_be_o=4'b1000, mem_wdata_o[31:24]=0xAB; empty_o=1 the cycle after.
- gnt held 0, five SW beats (0x10,0x14,0x18,0x1C,0x20) -> st_ready_o=0 after the fourth; the fifth is held. Release gnt -> writes drain 0x10,0x14,0x18,0x1C,0x20 in order.
- Pending SH to 0x42 (be 1100), load byte 0x43 -> ld_hazard_o=1; load byte 0x41 -> ld_hazard_o=0; after the SH is granted, load at 0x43 -> ld_hazard_o=0.
- Full buffer (count=4) with push and pop in the same cycle -> push refused (st_ready_o=0), count_o goes 4->3. Next cycle the push is accepted with a pop -> count_o stays 3.
- Three entries pending, gnt=0, rst_ni pulled low one cycle -> count_o=0, mem_req_o=0, empty_o=1 after the edge; no stale write is issued afterwards.
- st_valid_i=1 with write_en=4'b0000 -> count_o unchanged, mem_req_o stays 0.
